// File: rtl/event_trigger_mapper.sv
// event_trigger_mapper: event-code stream to per-output trigger strobes.
// Optional drop counter built when EVENT_TRIGGER_DROP_COUNT_EN is defined.
module event_trigger_mapper #(
  parameter int NUM_TRIGGERS  = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                    evrClk,
  input  logic                    evrRst_n,
  input  logic                    evrCsrStrobe,
  input  logic [31:0]             evrCsrData,
  input  logic [7:0]              eventCode,
  input  logic                    eventValid,
  output logic                    busy,
  output logic [NUM_TRIGGERS-1:0] triggerStrobe,
  output logic [15:0]             dropCount
);

  localparam int NT = NUM_TRIGGERS;
  localparam int HW = HOLDOFF_WIDTH;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t state;
  state_t stateNext;

  logic [7:0]    clrAddr;
  logic [7:0]    clrAddrNext;

  logic [1:0]    csrOp;
  logic [3:0]    holdIdx;
  logic          opSetMap;
  logic          opSetHold;
  logic          opClear;
  logic          inRun;
  logic          mapWrEn;
  logic          clearReq;
  logic          unusedCsr;

  logic          ramWe;
  logic [7:0]    ramWaddr;
  logic [NT-1:0] ramWdata;
  logic [NT-1:0] maskRam [256];
  logic [NT-1:0] maskRd;
  logic          rdValid;

  logic [HW-1:0] holdVal [NT];
  logic [HW-1:0] holdCnt [NT];
  logic [NT-1:0] holdActive;
  logic [NT-1:0] fire;

  assign csrOp     = evrCsrData[31:30];
  assign holdIdx   = evrCsrData[27:24];
  assign opSetMap  = evrCsrStrobe && (csrOp == 2'd0);
  assign opSetHold = evrCsrStrobe && (csrOp == 2'd1);
  assign opClear   = evrCsrStrobe && (csrOp == 2'd2);
  assign inRun     = (state == S_RUN);
  assign mapWrEn   = opSetMap && inRun;
  assign clearReq  = opClear && inRun;

  // Bits outside the active fields are don't-care.
  assign unusedCsr = ^evrCsrData;

  // State register: reset parks the sweep at address 0.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      state   <= S_CLEAR;
      clrAddr <= 8'd0;
    end else begin
      state   <= stateNext;
      clrAddr <= clrAddrNext;
    end
  end

  // Next state: sweep 256 entries, or restart on CLEAR.
  always_comb begin
    stateNext   = state;
    clrAddrNext = clrAddr;
    unique case (state)
      S_CLEAR: begin
        clrAddrNext = clrAddr + 8'd1;
        if (clrAddr == 8'hFF) begin
          stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (clearReq) begin
          stateNext   = S_CLEAR;
          clrAddrNext = 8'd0;
        end
      end
    endcase
  end

  // Outputs: sweep owns the RAM write port while clearing.
  always_comb begin
    busy     = 1'b0;
    ramWe    = 1'b0;
    ramWaddr = 8'd0;
    ramWdata = '0;
    unique case (state)
      S_CLEAR: begin
        busy     = 1'b1;
        ramWe    = 1'b1;
        ramWaddr = clrAddr;
      end
      S_RUN: begin
        ramWe    = mapWrEn;
        ramWaddr = evrCsrData[23:16];
        ramWdata = evrCsrData[NT-1:0];
      end
    endcase
  end

  // Mask RAM: read-first, so a same-cycle write is seen next event.
  always_ff @(posedge evrClk) begin
    if (ramWe) begin
      maskRam[ramWaddr] <= ramWdata;
    end
    maskRd <= maskRam[eventCode];
  end

  // Read-stage valid; events are dropped while sweeping.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      rdValid <= 1'b0;
    end else begin
      rdValid <= eventValid && inRun;
    end
  end

  // Holdoff reload values; out-of-range indices match no entry.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      for (int i = 0; i < NT; i++) begin
        holdVal[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (opSetHold && (holdIdx == 4'(i))) begin
          holdVal[i] <= evrCsrData[HW-1:0];
        end
      end
    end
  end

  // A counter is blocking whenever it is non-zero.
  always_comb begin
    holdActive = '0;
    for (int i = 0; i < NT; i++) begin
      holdActive[i] = (holdCnt[i] != '0);
    end
  end

  assign fire = (rdValid && inRun) ? (maskRd & ~holdActive) : '0;

  // Holdoff countdown: reload on fire, else count toward zero.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      for (int i = 0; i < NT; i++) begin
        holdCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (fire[i]) begin
          holdCnt[i] <= holdVal[i];
        end else if (holdActive[i]) begin
          holdCnt[i] <= holdCnt[i] - 1'b1;
        end
      end
    end
  end

  // Registered one-cycle strobes to the output drivers.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      triggerStrobe <= '0;
    end else begin
      triggerStrobe <= fire;
    end
  end

`ifdef EVENT_TRIGGER_DROP_COUNT_EN
  logic [NT-1:0] suppress;
  logic [15:0]   dropCnt;

  assign suppress = (rdValid && inRun) ? (maskRd & holdActive) : '0;

  // Saturating count of cycles with any holdoff-suppressed trigger.
  always_ff @(posedge evrClk) begin
    if (!evrRst_n) begin
      dropCnt <= 16'h0000;
    end else if (clearReq) begin
      dropCnt <= 16'h0000;
    end else if ((|suppress) && (dropCnt != 16'hFFFF)) begin
      dropCnt <= dropCnt + 16'd1;
    end
  end

  assign dropCount = dropCnt;
`else
  assign dropCount = 16'h0000;
`endif

endmodule
